// File: rtl/dmem_lat_if.sv
// dmem_lat_if: the load/store port between the MIPS core and dmem_lat.
//   master (core)  : drives req, we, a, wd, be; observes rd, ready, busy, err
//   slave  (memory): the reverse
// Signals:
//   req   access request, sampled only when the memory is idle or responding
//   we    1 = write, 0 = read
//   a     byte address; word index is a[31:2]
//   wd    write data
//   be    byte enables for writes, bit i covers wd[8i+7:8i]
//   rd    response data, valid while ready = 1
//   ready one-cycle response strobe
//   busy  high while a request is in flight
//   err   out-of-range flag, valid while ready = 1
interface dmem_lat_if #(
    parameter int WIDTH = 32
);
    logic               req;
    logic               we;
    logic [31:0]        a;
    logic [WIDTH-1:0]   wd;
    logic [WIDTH/8-1:0] be;
    logic [WIDTH-1:0]   rd;
    logic               ready;
    logic               busy;
    logic               err;

    modport master (
        output req, we, a, wd, be,
        input  rd, ready, busy, err
    );

    modport slave (
        input  req, we, a, wd, be,
        output rd, ready, busy, err
    );
endinterface

// File: rtl/dmem_lat.sv
// dmem_lat: multi-cycle data memory for the core's load/store path.
// One request at a time; a request is accepted in IDLE or RESP, waits
// LATENCY edges in WAIT, and its result is presented for one cycle in RESP.
// Ports:
//   clk_i    clock, all state updates on the rising edge
//   reset_i  synchronous, active-high reset
//   bus      dmem_lat_if slave modport (request/response handshake)
// Parameters:
//   WIDTH    data word width, multiple of 8
//   DEPTH    number of words, power of 2, >= 2
//   LATENCY  edges from acceptance to access, 1..15
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no request outstanding; accept req
// WAIT  | request latched, counter running down; req ignored, busy = 1
// RESP  | ready = 1 with rd/err from the access edge; req accepted again
module dmem_lat #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    dmem_lat_if.slave  bus
);
    localparam int NB = WIDTH / 8;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [29:0]       addr_q, addr_d;
    logic [WIDTH-1:0]  wd_q, wd_d;
    logic [NB-1:0]     be_q, be_d;
    logic [WIDTH-1:0]  rd_q, rd_d;
    logic              err_q, err_d;

    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              accept;
    logic              in_range;
    logic [AW-1:0]     idx;
    logic [WIDTH-1:0]  cur_word;
    logic [WIDTH-1:0]  merged;
    logic              mem_we;

    // Byte offset is not part of the word address.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^bus.a[1:0];

    // Full 30-bit compare so that high addresses never alias onto low words.
    assign in_range = (addr_q < 30'(DEPTH));
    assign idx      = addr_q[AW-1:0];
    assign cur_word = mem_q[idx];

    always_comb begin
        merged = cur_word;
        for (int i = 0; i < NB; i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = wd_q[8*i +: 8];
            end
        end
    end

    assign accept = bus.req && ((state_q == ST_IDLE) || (state_q == ST_RESP));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        be_d    = be_q;
        rd_d    = rd_q;
        err_d   = 1'b0;
        mem_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    mem_we  = we_q && in_range;
                    if (!in_range) begin
                        rd_d = '0;
                    end else if (we_q) begin
                        rd_d = merged;
                    end else begin
                        rd_d = cur_word;
                    end
                    err_d   = !in_range;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = accept ? ST_WAIT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            cnt_d  = 4'(LATENCY);
            we_d   = bus.we;
            addr_d = bus.a[31:2];
            wd_d   = bus.wd;
            be_d   = bus.be;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            be_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    // Array is deliberately not reset; a reset on the access edge drops the write.
    always_ff @(posedge clk_i) begin
        if (!reset_i && mem_we) begin
            mem_q[idx] <= merged;
        end
    end

    assign bus.rd    = rd_q;
    assign bus.err   = err_q;
    assign bus.ready = (state_q == ST_RESP);
    assign bus.busy  = (state_q == ST_WAIT);
endmodule

// File: tb/tb_dmem_lat.sv
// Directed testbench for dmem_lat: three instances with LATENCY 2, 1 and 15.
module tb_dmem_lat;
    logic clk_i = 1'b0;
    logic reset_i;

    always #5 clk_i = ~clk_i;

    dmem_lat_if #(.WIDTH(32)) bus2 ();
    dmem_lat_if #(.WIDTH(32)) bus1 ();
    dmem_lat_if #(.WIDTH(32)) bus15 ();

    dmem_lat #(.WIDTH(32), .DEPTH(64), .LATENCY(2))  u_dut2  (.clk_i(clk_i), .reset_i(reset_i), .bus(bus2));
    dmem_lat #(.WIDTH(32), .DEPTH(64), .LATENCY(1))  u_dut1  (.clk_i(clk_i), .reset_i(reset_i), .bus(bus1));
    dmem_lat #(.WIDTH(32), .DEPTH(64), .LATENCY(15)) u_dut15 (.clk_i(clk_i), .reset_i(reset_i), .bus(bus15));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Single request on the LATENCY=2 instance; k counts negedges until ready.
    task automatic access2(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, output logic [31:0] rdv,
                           output logic errv, output int k);
        @(negedge clk_i);
        bus2.req = 1'b1; bus2.we = we; bus2.a = a; bus2.wd = wd; bus2.be = be;
        @(negedge clk_i);
        bus2.req = 1'b0;
        k = 1;
        while (!bus2.ready && k < 40) begin
            @(negedge clk_i);
            k++;
        end
        rdv  = bus2.rd;
        errv = bus2.err;
    endtask

    // Request on a given bus, then pulse req throughout WAIT; count busy/ready cycles.
`define SWEEP(BUS, LAT, TAG) \
    begin \
        int nb, nr, both; \
        logic [31:0] rdv; \
        nb = 0; nr = 0; both = 0; rdv = '0; \
        @(negedge clk_i); \
        BUS.req = 1'b1; BUS.we = 1'b1; BUS.a = 32'd12; BUS.wd = 32'h0000CAFE; BUS.be = 4'hF; \
        for (int i = 0; i < LAT + 6; i++) begin \
            @(negedge clk_i); \
            if (BUS.busy) nb++; \
            if (BUS.ready) begin nr++; rdv = BUS.rd; end \
            if (BUS.busy && BUS.ready) both++; \
            BUS.wd = 32'hDEAD0000; \
            BUS.req = BUS.busy; \
        end \
        BUS.req = 1'b0; \
        check({TAG, "_busy_cycles"}, nb, LAT); \
        check({TAG, "_ready_cycles"}, nr, 1); \
        check({TAG, "_busy_and_ready"}, both, 0); \
        check({TAG, "_rd"}, rdv, 32'h0000CAFE); \
    end

    initial begin
        logic [31:0] rdv;
        logic        errv;
        int          k, k2, nrdy;

        reset_i = 1'b1;
        bus2.req = 0;  bus2.we = 0;  bus2.a = 0;  bus2.wd = 0;  bus2.be = 0;
        bus1.req = 0;  bus1.we = 0;  bus1.a = 0;  bus1.wd = 0;  bus1.be = 0;
        bus15.req = 0; bus15.we = 0; bus15.a = 0; bus15.wd = 0; bus15.be = 0;
        repeat (3) @(negedge clk_i);
        check("rst_ready", bus2.ready, 0);
        check("rst_busy", bus2.busy, 0);
        check("rst_err", bus2.err, 0);
        check("rst_rd", bus2.rd, 0);
        check("rst_busy1", bus1.busy, 0);
        check("rst_ready15", bus15.ready, 0);
        reset_i = 1'b0;

        // single write then read
        access2(1'b1, 32'd84, 32'h00000007, 4'hF, rdv, errv, k);
        check("wr84_latency", k, 3);
        check("wr84_err", errv, 0);
        check("wr84_rd", rdv, 32'h00000007);
        access2(1'b0, 32'd84, 32'h0, 4'h0, rdv, errv, k);
        check("rd84_rd", rdv, 32'h00000007);
        check("rd84_err", errv, 0);

        // byte lanes
        access2(1'b1, 32'd80, 32'hAABBCCDD, 4'hF, rdv, errv, k);
        access2(1'b1, 32'd80, 32'h11223344, 4'b0101, rdv, errv, k);
        check("lane_wr_rd", rdv, 32'hAA22CC44);
        access2(1'b0, 32'd80, 32'h0, 4'hF, rdv, errv, k);
        check("lane_rd", rdv, 32'hAA22CC44);

        // be = 0 write leaves word alone and still completes
        access2(1'b1, 32'd84, 32'hFFFFFFFF, 4'h0, rdv, errv, k);
        check("be0_latency", k, 3);
        check("be0_rd", rdv, 32'h00000007);

        // back-to-back write then read at a=8
        @(negedge clk_i);
        bus2.req = 1'b1; bus2.we = 1'b1; bus2.a = 32'd8; bus2.wd = 32'h5; bus2.be = 4'hF;
        k = 0;
        do begin @(negedge clk_i); k++; end while (!bus2.ready && k < 40);
        check("b2b_first_rd", bus2.rd, 32'h5);
        bus2.we = 1'b0; bus2.wd = 32'h0;
        @(negedge clk_i);
        bus2.req = 1'b0;
        k2 = 1;
        while (!bus2.ready && k2 < 40) begin @(negedge clk_i); k2++; end
        check("b2b_gap", k2, 3);
        check("b2b_second_rd", bus2.rd, 32'h5);

        // out of range: word 64 must not alias onto word 0; word 63 is in range
        access2(1'b1, 32'd0, 32'h12345678, 4'hF, rdv, errv, k);
        access2(1'b1, 32'd256, 32'hFFFFFFFF, 4'hF, rdv, errv, k);
        check("oor_ready_seen", k, 3);
        check("oor_err", errv, 1);
        check("oor_rd", rdv, 32'h0);
        access2(1'b0, 32'd0, 32'h0, 4'h0, rdv, errv, k);
        check("oor_noalias_rd", rdv, 32'h12345678);
        check("oor_noalias_err", errv, 0);
        access2(1'b1, 32'd252, 32'h0000ABCD, 4'hF, rdv, errv, k);
        check("last_word_err", errv, 0);
        check("last_word_rd", rdv, 32'h0000ABCD);
        @(negedge clk_i);
        check("err_low_outside_resp", bus2.err, 0);

        // reset during WAIT discards the write
        access2(1'b1, 32'd4, 32'h1, 4'hF, rdv, errv, k);
        @(negedge clk_i);
        bus2.req = 1'b1; bus2.we = 1'b1; bus2.a = 32'd4; bus2.wd = 32'h9; bus2.be = 4'hF;
        @(negedge clk_i);
        bus2.req = 1'b0;
        check("midrst_busy_before", bus2.busy, 1);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        check("midrst_busy_after", bus2.busy, 0);
        nrdy = (bus2.ready === 1'b1) ? 1 : 0;
        repeat (4) begin
            @(negedge clk_i);
            if (bus2.ready === 1'b1) nrdy++;
        end
        check("midrst_no_ready", nrdy, 0);
        access2(1'b0, 32'd4, 32'h0, 4'h0, rdv, errv, k);
        check("midrst_rd", rdv, 32'h1);

        // latency sweep
        `SWEEP(bus1, 1, "lat1")
        `SWEEP(bus15, 15, "lat15")

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
